mem_responder_sram: RTL

//  Memory-side responder for the core's mem_valid/mem_ready bus: answers fetch, load and store

---
 rtl/mem_responder_sram.sv | 105 ++++++++++
 1 files changed

// File: rtl/mem_responder_sram.sv
// Purpose : word-wide SRAM responder for the core's mem_valid/mem_ready bus. It inserts a
//           programmable number of wait states and flags out-of-range accesses.
// Latency : mem_ready is high 1+W cycles after valid is first sampled in IDLE.
//           W is READ_WAIT for reads and WRITE_WAIT for writes.
// Backpressure: the initiator holds valid, addr, wstrb and wdata stable until mem_ready.
//           Dropping valid during WAIT aborts the request with no write and no pulse.
// Ports   : clk, reset (sync, active-high)
//           mem_valid, mem_addr, mem_wstrb, mem_wdata in
//           mem_ready, mem_rdata, mem_fault out (all registered)
module mem_responder_sram #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          READ_WAIT   = 1,
  parameter int          WRITE_WAIT  = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_wdata,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_fault
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  RW   = 4'(READ_WAIT);
  localparam logic [3:0]  WW   = 4'(WRITE_WAIT);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t         state, state_nxt;
  logic [3:0]     cnt, cnt_nxt, w_sel;
  logic [31:0]    off;
  logic           in_range, is_write, enter_ack;
  logic [AW-1:0]  idx;
  logic [31:0]    ram [DEPTH_WORDS];

  // The request is never latched: decode always follows the live bus.
  assign off      = mem_addr - BASE_ADDR;
  assign in_range = {1'b0, off} < SPAN;
  assign idx      = off[AW+1:2];
  assign is_write = |mem_wstrb;
  assign w_sel    = is_write ? WW : RW;

  assign mem_ready = (state == ACK);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (mem_valid) begin
          if (w_sel == 4'd0) begin
            state_nxt = ACK;
          end else begin
            cnt_nxt   = w_sel;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (!mem_valid) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 4'd1;
          if (cnt == 4'd1) state_nxt = ACK;
        end
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ACK always returns to IDLE, so a next state of ACK always means we are entering it.
  assign enter_ack = (state_nxt == ACK);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      mem_rdata <= 32'd0;
      mem_fault <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      mem_fault <= enter_ack && !in_range;
      // Read data and fault both hold only for the ACK cycle and are zero at all other times.
      mem_rdata <= (enter_ack && !is_write && in_range) ? ram[idx] : 32'd0;
    end
  end

  // Reset does not clear the RAM. The write commits at the end of ACK using the values
  // present on the bus in the ACK cycle.
  always_ff @(posedge clk) begin
    if (!reset && state == ACK && in_range && is_write) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_wstrb[i]) ram[idx][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

endmodule
